// File: rtl/icache_ctrl_pkg.sv
// Shared configuration for the instruction cache controller: default geometry,
// controller state encoding and common constants.
package icache_ctrl_pkg;

   localparam int DEF_ADDR_LEN   = 32;
   localparam int DEF_INST_LEN   = 32;
   localparam int DEF_INDEX_BITS = 7;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;
   localparam logic [DEF_INST_LEN-1:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MISS = 1'b1
   } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for the direct-mapped instruction cache: one
// combinational read port, one synchronous write port, no reset.
module icache_array
   import icache_ctrl_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = DEF_ADDR_LEN - DEF_INDEX_BITS - 2,
   parameter int INST_LEN   = DEF_INST_LEN
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [INST_LEN-1:0]   rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [INST_LEN-1:0]   wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [TAG_BITS-1:0] tag_mem_r  [LINES];
   logic [INST_LEN-1:0] data_mem_r [LINES];

   assign rd_tag  = tag_mem_r[rd_index];
   assign rd_data = data_mem_r[rd_index];

   // Line fill write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem_r[wr_index]  <= wr_tag;
         data_mem_r[wr_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller sitting between
// the fetch stage and the fetch port of the memory controller.
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int ADDR_LEN   = DEF_ADDR_LEN,
   parameter int INST_LEN   = DEF_INST_LEN,
   parameter int INDEX_BITS = DEF_INDEX_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic [ADDR_LEN-1:0] pc_addr,
   input  logic                pc_valid,
   output logic [INST_LEN-1:0] inst,
   output logic                inst_valid,
   output logic [ADDR_LEN-1:0] mc_addr,
   output logic                mc_request,
   input  logic [INST_LEN-1:0] mc_inst,
   input  logic                mc_enable,
   input  logic                jump_or_not,
   input  logic                invalidate
);

   localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;
   localparam int LINES    = 1 << INDEX_BITS;

   state_t              state_r, state_s;
   logic [INST_LEN-1:0] inst_r, inst_s;
   logic                inst_valid_r, inst_valid_s;
   logic [ADDR_LEN-1:0] mc_addr_r, mc_addr_s;
   logic                mc_request_r, mc_request_s;
   logic [LINES-1:0]    valid_r;
   logic                fill_s;
   logic                wr_en_s;
   logic                hit_s;

   logic [INDEX_BITS-1:0] pc_index_s, fill_index_s;
   logic [TAG_BITS-1:0]   pc_tag_s, fill_tag_s, rd_tag_s;
   logic [INST_LEN-1:0]   rd_data_s;

   assign pc_index_s   = pc_addr[INDEX_BITS+1:2];
   assign pc_tag_s     = pc_addr[ADDR_LEN-1:INDEX_BITS+2];
   assign fill_index_s = mc_addr_r[INDEX_BITS+1:2];
   assign fill_tag_s   = mc_addr_r[ADDR_LEN-1:INDEX_BITS+2];
   assign hit_s        = valid_r[pc_index_s] && (rd_tag_s == pc_tag_s);

   // The array must not change while stalled or in reset
   assign wr_en_s = rst && rdy && fill_s;

   icache_array #(
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS),
      .INST_LEN  (INST_LEN)
   ) u_array (
      .clk     (clk),
      .rd_index(pc_index_s),
      .rd_tag  (rd_tag_s),
      .rd_data (rd_data_s),
      .wr_en   (wr_en_s),
      .wr_index(fill_index_s),
      .wr_tag  (fill_tag_s),
      .wr_data (mc_inst)
   );

   // Next-state and output decode; a redirect overrides everything else
   always_comb begin
      state_s      = state_r;
      inst_s       = inst_r;
      inst_valid_s = False;
      mc_addr_s    = mc_addr_r;
      mc_request_s = mc_request_r;
      fill_s       = False;
      if (jump_or_not) begin
         state_s      = ST_IDLE;
         mc_request_s = False;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pc_valid && hit_s) begin
                  inst_s       = rd_data_s;
                  inst_valid_s = True;
               end else if (pc_valid) begin
                  state_s      = ST_MISS;
                  mc_addr_s    = pc_addr;
                  mc_request_s = True;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_MISS: begin
               if (mc_enable) begin
                  fill_s       = True;
                  inst_s       = mc_inst;
                  inst_valid_s = True;
                  mc_request_s = False;
                  state_s      = ST_IDLE;
               end else begin
                  mc_request_s = True;
               end
            end
            default: begin
               state_s      = ST_IDLE;
               mc_request_s = False;
            end
         endcase
      end
   end

   // Registered state, outputs and valid vector; invalidate beats a same-cycle fill
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         inst_r       <= {INST_LEN{1'b0}};
         inst_valid_r <= 1'b0;
         mc_addr_r    <= {ADDR_LEN{1'b0}};
         mc_request_r <= 1'b0;
         valid_r      <= {LINES{1'b0}};
      end else if (rdy) begin
         state_r      <= state_s;
         inst_r       <= inst_s;
         inst_valid_r <= inst_valid_s;
         mc_addr_r    <= mc_addr_s;
         mc_request_r <= mc_request_s;
         if (invalidate) begin
            valid_r <= {LINES{1'b0}};
         end else if (fill_s) begin
            valid_r[fill_index_s] <= 1'b1;
         end
      end
   end

   assign inst       = inst_r;
   assign inst_valid = inst_valid_r;
   assign mc_addr    = mc_addr_r;
   assign mc_request = mc_request_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed scenarios followed by random
// traffic, checked against a line-level cache model and a fixed memory image.
module tb_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, pc_valid, mc_enable, jump_or_not, invalidate;
   logic [31:0] pc_addr, mc_inst, inst, mc_addr;
   logic        inst_valid, mc_request;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_addr_q[$];
   logic        req_prev = 1'b0;

   // reference model: one entry per cache line
   bit          m_valid[128];
   logic [22:0] m_tag[128];
   logic [31:0] m_data[128];

   always #5 clk = ~clk;

   icache_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .pc_addr(pc_addr), .pc_valid(pc_valid),
      .inst(inst), .inst_valid(inst_valid), .mc_addr(mc_addr), .mc_request(mc_request),
      .mc_inst(mc_inst), .mc_enable(mc_enable), .jump_or_not(jump_or_not),
      .invalidate(invalidate)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0000_0013;
      else if (a == 32'h0000_0200) return 32'h0010_0093;
      else return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Monitor: every returned instruction and every new memory request is popped and compared
   always @(negedge clk) begin
      if (inst_valid) begin
         if (exp_inst_q.size() == 0) chk("unexpected_inst_valid", 32'(inst_valid), 32'd0);
         else chk("inst", inst, exp_inst_q.pop_front());
      end
      if (mc_request && !req_prev) begin
         if (exp_addr_q.size() == 0) chk("unexpected_mc_request", 32'(mc_request), 32'd0);
         else chk("mc_addr", mc_addr, exp_addr_q.pop_front());
      end
      req_prev <= mc_request;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
   endtask

   task automatic inval_pulse();
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      model_clear();
   endtask

   // jmode: 0 none, 1 jump with mc_enable (or with a hit), 2 jump before memory answers
   task automatic fetch(input logic [31:0] a, input int lat, input int jmode,
                        input bit inv, input int stall, input bit keep);
      logic [6:0]  idx;
      logic [22:0] tg;
      bit          hit;
      idx = a[8:2];
      tg  = a[31:9];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      pc_addr  = a;
      pc_valid = 1'b1;
      if (hit) begin
         if (jmode != 0) begin
            jump_or_not = 1'b1;
            tick();
            jump_or_not = 1'b0;
            pc_valid    = 1'b0;
            chk("hit_jump_valid", 32'(inst_valid), 32'd0);
         end else begin
            exp_inst_q.push_back(m_data[idx]);
            invalidate = inv;
            tick();
            invalidate = 1'b0;
            chk("hit_latency", 32'(inst_valid), 32'd1);
            chk("hit_no_req", 32'(mc_request), 32'd0);
            if (inv) model_clear();
            if (!keep) pc_valid = 1'b0;
         end
      end else begin
         exp_addr_q.push_back(a);
         tick();
         chk("miss_req", 32'(mc_request), 32'd1);
         repeat (lat) tick();
         if (stall > 0) begin
            rdy = 1'b0;
            repeat (stall) begin
               tick();
               chk("stall_req", 32'(mc_request), 32'd1);
               chk("stall_addr", mc_addr, a);
            end
            rdy = 1'b1;
         end
         if (jmode == 2) begin
            jump_or_not = 1'b1;
            tick();
            jump_or_not = 1'b0;
            pc_valid    = 1'b0;
            chk("jump_req", 32'(mc_request), 32'd0);
            mc_enable = 1'b1;
            mc_inst   = $urandom;
            tick();
            mc_enable = 1'b0;
         end else begin
            mc_enable = 1'b1;
            mc_inst   = mem_word(a);
            if (jmode == 1) jump_or_not = 1'b1;
            else begin
               exp_inst_q.push_back(mem_word(a));
               invalidate = inv;
            end
            tick();
            mc_enable   = 1'b0;
            jump_or_not = 1'b0;
            invalidate  = 1'b0;
            chk("done_req", 32'(mc_request), 32'd0);
            chk("done_valid", 32'(inst_valid), (jmode == 0) ? 32'd1 : 32'd0);
            if (jmode == 0) begin
               if (inv) model_clear();
               else begin
                  m_valid[idx] = 1'b1;
                  m_tag[idx]   = tg;
                  m_data[idx]  = mem_word(a);
               end
            end
            if (jmode != 0 || !keep) pc_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; pc_valid = 1'b0; pc_addr = 32'h0;
      mc_inst = 32'h0; mc_enable = 1'b0; jump_or_not = 1'b0; invalidate = 1'b0;
      model_clear();
      tick();
      tick();
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_mc_request", 32'(mc_request), 32'd0);
      chk("rst_mc_addr", mc_addr, 32'h0);
      rst = 1'b1;
      tick();

      fetch(32'h0000_0000, 5, 0, 1'b0, 0, 1'b0);   // cold miss
      fetch(32'h0000_0000, 0, 0, 1'b0, 0, 1'b0);   // hit
      fetch(32'h0000_0200, 2, 0, 1'b0, 0, 1'b0);   // conflict eviction
      fetch(32'h0000_0000, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_0104, 2, 1, 1'b0, 0, 1'b0);   // jump with mc_enable
      tick();
      fetch(32'h0000_0104, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_0008, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_000C, 0, 0, 1'b0, 0, 1'b0);
      inval_pulse();
      fetch(32'h0000_0008, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_000C, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_0010, 2, 0, 1'b0, 3, 1'b0);   // rdy stall mid-miss
      fetch(32'h0000_0008, 0, 0, 1'b0, 0, 1'b1);   // back-to-back hits
      fetch(32'h0000_000C, 0, 0, 1'b0, 0, 1'b1);
      fetch(32'h0000_0010, 0, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_000C, 0, 0, 1'b1, 0, 1'b0);   // hit with invalidate
      fetch(32'h0000_000C, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_0014, 1, 0, 1'b1, 0, 1'b0);   // fill with invalidate
      fetch(32'h0000_0014, 1, 0, 1'b0, 0, 1'b0);
      fetch(32'h0000_0300, 2, 2, 1'b0, 0, 1'b0);   // jump then stray mc_enable
      fetch(32'h0000_0014, 0, 1, 1'b0, 0, 1'b0);   // hit with jump
      tick();

      // reset while a miss is outstanding
      pc_addr  = 32'h0000_0040;
      pc_valid = 1'b1;
      exp_addr_q.push_back(32'h0000_0040);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      pc_valid = 1'b0;
      chk("rst_mid_req", 32'(mc_request), 32'd0);
      chk("rst_mid_addr", mc_addr, 32'h0);
      mc_enable = 1'b1;
      mc_inst   = 32'hDEAD_BEEF;
      tick();
      mc_enable = 1'b0;
      model_clear();
      repeat (3) tick();

      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         int          r, jm, st;
         bit          inv, kp;
         a   = {21'($urandom_range(0, 3)), 2'b00, 7'($urandom_range(0, 7)), 2'b00};
         r   = int'($urandom_range(0, 99));
         jm  = (r < 6) ? 1 : ((r < 10) ? 2 : 0);
         inv = ($urandom_range(0, 19) == 0);
         st  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
         kp  = (n != 249) && (jm == 0) && ($urandom_range(0, 1) == 1);
         fetch(a, int'($urandom_range(0, 3)), jm, inv, st, kp);
         if (!kp) begin
            if ($urandom_range(0, 29) == 0) inval_pulse();
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      repeat (5) tick();
      chk("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
      chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
